// File: rtl/sysbus_arbiter_pkg.sv
// Shared types and limits for the system bus arbiter: FSM states, owner
// encoding and the legal ranges of the timing parameters.
package sysbus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        ACCESS,
        RECOVER
    } bus_state_t;

    typedef enum logic {
        OwnCpu,
        OwnDma
    } bus_owner_t;

    localparam int unsigned WAIT_MAX   = 7;
    localparam int unsigned STARVE_MAX = 15;

endpackage

// File: rtl/sysbus_arbiter_prio.sv
// Grant logic for the bus arbiter: fixed CPU priority with a saturating
// DMA starvation counter that hands the bus to DMA once the limit is reached.
module sysbus_prio
    import sysbus_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic       Clock,
    input  logic       nReset,
    input  logic       arb_en_i,
    input  logic       cpu_req_i,
    input  logic       dma_req_i,
    input  logic       lock_i,
    output logic       grant_o,
    output bus_owner_t grant_owner_o
);

    localparam logic [3:0] LIMIT = (STARVE_LIMIT > STARVE_MAX) ? 4'(STARVE_MAX) :
                                   (STARVE_LIMIT == 0)         ? 4'd1 : 4'(STARVE_LIMIT);

    logic [3:0] starve_q, starve_d;
    logic       dma_live;
    logic       dma_wins;

    always_comb begin
        // A held lock makes the DMA request invisible, which also freezes the counter.
        dma_live      = dma_req_i && !lock_i;
        dma_wins      = dma_live && (!cpu_req_i || (starve_q == LIMIT));
        grant_o       = arb_en_i && (cpu_req_i || dma_live);
        grant_owner_o = dma_wins ? OwnDma : OwnCpu;
        starve_d      = starve_q;
        if (grant_o) begin
            if (dma_wins) begin
                starve_d = 4'd0;
            end else if (dma_live && (starve_q != LIMIT)) begin
                starve_d = starve_q + 4'd1;
            end
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            starve_q <= 4'd0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/sysbus_arbiter.sv
// Two-port arbiter for the multiplexed external memory bus; generates all
// ALE/nME/nOE/nWE/ENB timing from registers. Optional bus locking: BUS_LOCK_EN.
module sysbus_arbiter
    import sysbus_arbiter_pkg::*;
#(
    parameter int unsigned WAIT_STATES  = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        Clock,
    input  logic        nReset,
    input  logic        CpuReq,
    input  logic        CpuWrite,
    input  logic [15:0] CpuAddr,
    input  logic [15:0] CpuWData,
    output logic        CpuAck,
    output logic [15:0] CpuRData,
    input  logic        CpuLock,
    input  logic        DmaReq,
    input  logic        DmaWrite,
    input  logic [15:0] DmaAddr,
    input  logic [15:0] DmaWData,
    output logic        DmaAck,
    output logic [15:0] DmaRData,
    output logic [15:0] BusOut,
    output logic        ENB,
    input  logic [15:0] BusIn,
    output logic        ALE,
    output logic        nME,
    output logic        nOE,
    output logic        nWE,
    output logic        Owner
);

    localparam logic [2:0] WS = (WAIT_STATES > WAIT_MAX) ? 3'(WAIT_MAX) : 3'(WAIT_STATES);

    bus_state_t  state_q, state_d;
    bus_owner_t  owner_q, owner_d;
    logic [2:0]  wait_q, wait_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        write_q, write_d;
    logic [15:0] cpu_rdata_q, cpu_rdata_d;
    logic [15:0] dma_rdata_q, dma_rdata_d;
    logic        ale_q, ale_d, nme_q, nme_d, noe_q, noe_d, nwe_q, nwe_d, enb_q, enb_d;
    logic [15:0] bus_out_q, bus_out_d;
    logic        cpu_ack_q, cpu_ack_d, dma_ack_q, dma_ack_d;
    logic        lock_w;
    logic        grant;
    bus_owner_t  grant_owner;

`ifdef BUS_LOCK_EN
    logic lock_q, lock_d;
    assign lock_w = lock_q;
`else
    logic unused_cpu_lock;
    assign unused_cpu_lock = CpuLock;
    assign lock_w          = 1'b0;
`endif

    sysbus_prio #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_prio (
        .Clock         (Clock),
        .nReset        (nReset),
        .arb_en_i      (state_q == IDLE),
        .cpu_req_i     (CpuReq),
        .dma_req_i     (DmaReq),
        .lock_i        (lock_w),
        .grant_o       (grant),
        .grant_owner_o (grant_owner)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        wait_d      = wait_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        write_d     = write_q;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
`ifdef BUS_LOCK_EN
        lock_d      = lock_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d = ADDR;
                    owner_d = grant_owner;
                    if (grant_owner == OwnDma) begin
                        addr_d  = DmaAddr;
                        wdata_d = DmaWData;
                        write_d = DmaWrite;
                    end else begin
                        addr_d  = CpuAddr;
                        wdata_d = CpuWData;
                        write_d = CpuWrite;
                    end
                end
            end
            ADDR: begin
                state_d = ACCESS;
                wait_d  = WS;
            end
            ACCESS: begin
                if (wait_q == 3'd0) begin
                    state_d = RECOVER;
                    if (!write_q) begin
                        if (owner_q == OwnDma) begin
                            dma_rdata_d = BusIn;
                        end else begin
                            cpu_rdata_d = BusIn;
                        end
                    end
                end else begin
                    wait_d = wait_q - 3'd1;
                end
            end
            RECOVER: begin
                state_d = IDLE;
`ifdef BUS_LOCK_EN
                if (owner_q == OwnCpu) begin
                    lock_d = CpuLock;
                end
`endif
            end
            default: state_d = IDLE;
        endcase

        // Pad outputs are decoded from the next state so they leave the flops aligned with it.
        ale_d     = 1'b0;
        nme_d     = 1'b1;
        noe_d     = 1'b1;
        nwe_d     = 1'b1;
        enb_d     = 1'b0;
        bus_out_d = 16'h0000;
        cpu_ack_d = 1'b0;
        dma_ack_d = 1'b0;
        case (state_d)
            ADDR: begin
                nme_d     = 1'b0;
                ale_d     = 1'b1;
                enb_d     = 1'b1;
                bus_out_d = addr_d;
            end
            ACCESS: begin
                nme_d = 1'b0;
                if (write_d) begin
                    enb_d     = 1'b1;
                    bus_out_d = wdata_d;
                    // Last cycle releases nWE as data hold; with no wait states there is no spare cycle.
                    nwe_d     = (WS != 3'd0) && (wait_d == 3'd0);
                end else begin
                    noe_d = 1'b0;
                end
            end
            RECOVER: begin
                cpu_ack_d = (owner_d == OwnCpu);
                dma_ack_d = (owner_d == OwnDma);
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q     <= IDLE;
            owner_q     <= OwnCpu;
            wait_q      <= 3'd0;
            addr_q      <= 16'h0000;
            wdata_q     <= 16'h0000;
            write_q     <= 1'b0;
            cpu_rdata_q <= 16'h0000;
            dma_rdata_q <= 16'h0000;
            ale_q       <= 1'b0;
            nme_q       <= 1'b1;
            noe_q       <= 1'b1;
            nwe_q       <= 1'b1;
            enb_q       <= 1'b0;
            bus_out_q   <= 16'h0000;
            cpu_ack_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            wait_q      <= wait_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            write_q     <= write_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
            ale_q       <= ale_d;
            nme_q       <= nme_d;
            noe_q       <= noe_d;
            nwe_q       <= nwe_d;
            enb_q       <= enb_d;
            bus_out_q   <= bus_out_d;
            cpu_ack_q   <= cpu_ack_d;
            dma_ack_q   <= dma_ack_d;
        end
    end

`ifdef BUS_LOCK_EN
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            lock_q <= 1'b0;
        end else begin
            lock_q <= lock_d;
        end
    end
`endif

    assign CpuAck   = cpu_ack_q;
    assign DmaAck   = dma_ack_q;
    assign CpuRData = cpu_rdata_q;
    assign DmaRData = dma_rdata_q;
    assign BusOut   = bus_out_q;
    assign ENB      = enb_q;
    assign ALE      = ale_q;
    assign nME      = nme_q;
    assign nOE      = noe_q;
    assign nWE      = nwe_q;
    assign Owner    = (owner_q == OwnDma);

endmodule
